mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Parametrised load/store stage between the execute stage and the writeback/forwarding path.
- Drives a data-memory port with byte enables, so stores need no read-modify-write.
- Supports a variable-latency memory through a req/ack handshake, stalling the pipeline while an access is outstanding.
- Detects misaligned accesses.
- Registers the writeback triple (rd address, rd data, write enable) for the next stage.

Parameters:
XLEN, 32, datapath width; 32 or 64 (64 adds LD/LWU/SD).
TIMEOUT_CYCLES, 255, maximum BUSY cycles before abort; used only with the optional feature.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
valid_i  in  1  instruction present from execute
rd_addr_i  in  5  destination register
rd_data_i  in  XLEN  ALU result, passed through for non-load instructions
rd_we_i  in  1  register write enable
mem_addr_i  in  XLEN  effective address
store_data_i  in  XLEN  store source operand
mem_re_i  in  1  load
mem_we_i  in  1  store
opfunc3_i  in  3  funct3 (width/sign)
dmem_req_o  out  1  access request
dmem_we_o  out  1  write
dmem_addr_o  out  XLEN  word-aligned address
dmem_be_o  out  XLEN/8  byte enables
dmem_wdata_o  out  XLEN  lane-replicated store data
dmem_rdata_i  in  XLEN  read data, valid with ack
dmem_ack_i  in  1  access complete
stall_o  out  1  hold execute and upstream stages
rd_addr_o  out  5  writeback address (registered)
rd_data_o  out  XLEN  writeback data (registered)
rd_we_o  out  1  writeback enable (registered)
misalign_o  out  1  one-cycle misalignment pulse (registered)
badaddr_o  out  XLEN  faulting address (registered)
bus_err_o  out  1  one-cycle timeout pulse (registered)

Behaviour:
- Reset (asynchronous): state IDLE; every registered output 0; dmem_req_o and stall_o drop immediately; all latched request fields cleared; an in-flight access is abandoned.
- Memory op: valid_i & (mem_re_i | mem_we_i).
- Aligned checks:
  - byte: always aligned.
  - half: addr[0] = 0.
  - word: addr[1:0] = 0.
  - double: addr[2:0] = 0.
- Illegal funct3: 011 or 110 when XLEN=32; 111 for any XLEN; store funct3 > 3 (or > 2 when XLEN=32).
- IDLE:
  - Non-memory op: register rd_* from inputs next edge; rd_we_o = rd_we_i & valid_i. No stall, latency 1.
  - Aligned legal memory op: stall_o = 1 combinationally. Latch addr, be, wdata, funct3, rd_addr and rd_we; go to BUSY. rd_we_o = 0 next cycle (bubble).
  - Misaligned op: no request. Next edge: misalign_o = 1, badaddr_o = mem_addr_i, rd_we_o = 0. No stall.
  - Illegal op: no request, no flag, rd_we_o = 0.
- BUSY:
  - dmem_req_o = 1; address, be, wdata and we held stable from latches.
  - stall_o = ~dmem_ack_i.
  - On ack edge: state goes to IDLE. A load registers rd_data_o = extracted lane and rd_we_o = latched rd_we. A store registers rd_we_o = 0.
  - Upstream advances on the same edge, so back-to-back memory ops have no dead cycle beyond the mandatory BUSY cycle. Minimum memory-op latency is 2 cycles.
- Address: dmem_addr_o = addr with the low log2(XLEN/8) bits cleared; off = those bits.
- Store lanes:
  - SB: be = 1 << off; wdata = byte replicated across all lanes.
  - SH: be = 2'b11 << off; wdata = halfword replicated.
  - SW: be = 4'hF << off; wdata = word replicated.
  - SD: be all ones.
- Load extract: field = rdata >> (8·off).
  - LB/LH/LW: sign-extend to XLEN.
  - LBU/LHU/LWU: zero-extend.
  - LW at XLEN=32 and LD: whole field, no extension.
- Ack while IDLE is ignored. mem_re_i & mem_we_i both set is treated as a store.

Optional Feature:
MEM_STAGE_TIMEOUT_EN:
- With it: an 8..16-bit counter runs in BUSY. When BUSY reaches TIMEOUT_CYCLES cycles without ack:
  - drop req and go to IDLE;
  - pulse bus_err_o, set badaddr_o = latched addr, rd_we_o = 0;
  - stall_o falls that cycle.
- Without it: BUSY waits indefinitely and bus_err_o is tied 0.

Decomposition:
- Shared defines/package:
  - funct3 codes: LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110;
  - state encoding (IDLE=0, BUSY=1);
  - byte-lane width macro.
- Sub-module lsu_lane_align (combinational, parametrised XLEN):
  - produces be/wdata from funct3/off/store_data;
  - produces the load extract from funct3/off/rdata;
  - produces the misaligned flag.
- The FSM, latches and writeback registers stay in the top.

Test Plan:
1. SB, addr 0x1003, store_data 0x000000A5, ack after 2 wait cycles -> addr 0x1000, be 4'b1000, wdata 0xA5A5A5A5; stall_o high 3 cycles; rd_we_o stays 0.
2. LB, addr 0x2001, rdata 0x00008000, ack on first BUSY cycle -> rd_data_o 0xFFFFFF80, rd_we_o 1. Same access as LBU -> 0x00000080.
3. LH at 0x2003 -> no req; misalign_o pulses one cycle; badaddr_o 0x2003; rd_we_o 0; stall_o 0.
4. LW 0x3000 then ADD (rd=5, data 0x1234) back-to-back -> load writes back, then ADD writes back the next cycle; no duplicated or lost instruction.
5. rst_i asserted mid-BUSY (between edges) -> dmem_req_o and stall_o drop immediately. After release, state IDLE, a new op is accepted, and the stale ack is ignored.
6. MEM_STAGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_err_o pulses after 4 BUSY cycles; req drops; rd_we_o 0.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants and types for the mem_stage_lsu load/store stage:
// funct3 width/sign codes, FSM state encoding and byte-lane helpers.
package mem_stage_lsu_pkg;

  localparam int BYTE_W = 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } lsu_state_e;

  function automatic int lanes(input int xlen);
    return xlen / BYTE_W;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory port between the load/store stage (master) and memory (slave).
interface mem_stage_lsu_if
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN = 32
);
  logic                      req;
  logic                      we;
  logic [XLEN-1:0]           addr;
  logic [lanes(XLEN)-1:0]    be;
  logic [XLEN-1:0]           wdata;
  logic [XLEN-1:0]           rdata;
  logic                      ack;

  modport master (output req, we, addr, be, wdata, input rdata, ack);
  modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage_lsu_lane_align.sv
// Combinational byte-lane logic: store enables/replicated data, load lane
// extraction with sign/zero extension, and legality/alignment of an access.
module lsu_lane_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB   = lanes(XLEN),
  localparam int OFFW = $clog2(NB)
) (
  input  logic [2:0]      funct3_i,
  input  logic [OFFW-1:0] off_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [2:0]      ld_funct3_i,
  input  logic [OFFW-1:0] ld_off_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [NB-1:0]   be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            misalign_o,
  output logic            illegal_o
);

  logic [XLEN-1:0] field_s;

  // Store lane enables and data replicated across every lane of its size
  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = NB'(1'b1) << off_i;
        wdata_o = {NB{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = NB'(2'b11) << off_i;
        wdata_o = {(XLEN/16){store_data_i[15:0]}};
      end
      2'b10: begin
        be_o    = NB'(4'hF) << off_i;
        wdata_o = {(XLEN/32){store_data_i[31:0]}};
      end
      default: begin
        be_o    = '1;
        wdata_o = store_data_i;
      end
    endcase
  end

  // Alignment follows access size; legality depends on XLEN and direction
  always_comb begin
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    case (funct3_i[1:0])
      2'b00:   misalign_o = 1'b0;
      2'b01:   misalign_o = off_i[0];
      2'b10:   misalign_o = |off_i[1:0];
      default: misalign_o = |off_i;
    endcase
    if (funct3_i == 3'b111) begin
      illegal_o = 1'b1;
    end else if ((XLEN == 32) && ((funct3_i == F3_LD) || (funct3_i == F3_LWU))) begin
      illegal_o = 1'b1;
    end else if (is_store_i && (funct3_i > ((XLEN == 32) ? 3'd2 : 3'd3))) begin
      illegal_o = 1'b1;
    end else begin
      illegal_o = 1'b0;
    end
  end

  assign field_s = rdata_i >> {ld_off_i, 3'b000};

  // Load extraction; at XLEN=32 the LW cast leaves the field unchanged
  always_comb begin
    load_data_o = '0;
    case (ld_funct3_i)
      F3_LB:   load_data_o = XLEN'($signed(field_s[7:0]));
      F3_LH:   load_data_o = XLEN'($signed(field_s[15:0]));
      F3_LW:   load_data_o = XLEN'($signed(field_s[31:0]));
      F3_LD:   load_data_o = field_s;
      F3_LBU:  load_data_o = XLEN'(field_s[7:0]);
      F3_LHU:  load_data_o = XLEN'(field_s[15:0]);
      F3_LWU:  load_data_o = XLEN'(field_s[31:0]);
      default: load_data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Load/store pipeline stage with req/ack data-memory handshake and
// registered writeback. Define MEM_STAGE_TIMEOUT_EN to abort stuck accesses.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [XLEN-1:0]   rd_data_i,
  input  logic              rd_we_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  logic [2:0]        opfunc3_i,
  mem_stage_lsu_if.master   dmem,
  output logic              stall_o,
  output logic [4:0]        rd_addr_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              rd_we_o,
  output logic              misalign_o,
  output logic [XLEN-1:0]   badaddr_o,
  output logic              bus_err_o
);

  localparam int NB   = lanes(XLEN);
  localparam int OFFW = $clog2(NB);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [NB-1:0]   be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic            st_q, st_d;
  logic [4:0]      lrd_addr_q, lrd_addr_d;
  logic            lrd_we_q, lrd_we_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            rd_we_q, rd_we_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] badaddr_q, badaddr_d;
  logic            bus_err_q, bus_err_d;

  logic            mem_op_s, stall_s, tmo_hit_s;
  logic            misalign_s, illegal_s;
  logic [NB-1:0]   be_s;
  logic [XLEN-1:0] wdata_s, load_s;

  assign mem_op_s = valid_i & (mem_re_i | mem_we_i);

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .funct3_i     (opfunc3_i),
    .off_i        (mem_addr_i[OFFW-1:0]),
    .is_store_i   (mem_we_i),
    .store_data_i (store_data_i),
    .ld_funct3_i  (f3_q),
    .ld_off_i     (addr_q[OFFW-1:0]),
    .rdata_i      (dmem.rdata),
    .be_o         (be_s),
    .wdata_o      (wdata_s),
    .load_data_o  (load_s),
    .misalign_o   (misalign_s),
    .illegal_o    (illegal_s)
  );

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? 16 : 8;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Count BUSY cycles; cleared in IDLE so each access starts from zero
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_BUSY) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1'b1);
    end else begin
      tmo_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign tmo_hit_s = (state_q == ST_BUSY) && !dmem.ack && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next state, request latches and writeback values
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    st_d       = st_q;
    lrd_addr_d = lrd_addr_q;
    lrd_we_d   = lrd_we_q;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    rd_we_d    = 1'b0;
    misalign_d = 1'b0;
    badaddr_d  = badaddr_q;
    bus_err_d  = 1'b0;
    stall_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!mem_op_s) begin
          rd_addr_d = rd_addr_i;
          rd_data_d = rd_data_i;
          rd_we_d   = rd_we_i & valid_i;
        end else if (illegal_s) begin
          rd_we_d = 1'b0;
        end else if (misalign_s) begin
          misalign_d = 1'b1;
          badaddr_d  = mem_addr_i;
        end else begin
          stall_s    = 1'b1;
          state_d    = ST_BUSY;
          addr_d     = mem_addr_i;
          be_d       = be_s;
          wdata_d    = wdata_s;
          f3_d       = opfunc3_i;
          st_d       = mem_we_i;
          lrd_addr_d = rd_addr_i;
          lrd_we_d   = rd_we_i;
        end
      end
      ST_BUSY: begin
        // Releasing the stall on ack lets the next instruction arrive on the same edge
        if (dmem.ack) begin
          state_d   = ST_IDLE;
          rd_addr_d = lrd_addr_q;
          if (st_q) begin
            rd_we_d = 1'b0;
          end else begin
            rd_data_d = load_s;
            rd_we_d   = lrd_we_q;
          end
        end else if (tmo_hit_s) begin
          state_d   = ST_IDLE;
          bus_err_d = 1'b1;
          badaddr_d = addr_q;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latches and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      f3_q       <= 3'b000;
      st_q       <= 1'b0;
      lrd_addr_q <= 5'd0;
      lrd_we_q   <= 1'b0;
      rd_addr_q  <= 5'd0;
      rd_data_q  <= '0;
      rd_we_q    <= 1'b0;
      misalign_q <= 1'b0;
      badaddr_q  <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      f3_q       <= f3_d;
      st_q       <= st_d;
      lrd_addr_q <= lrd_addr_d;
      lrd_we_q   <= lrd_we_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      rd_we_q    <= rd_we_d;
      misalign_q <= misalign_d;
      badaddr_q  <= badaddr_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Reset must kill req and stall immediately, not at the next edge
  assign dmem.req   = (state_q == ST_BUSY) & ~rst_i;
  assign dmem.we    = st_q;
  assign dmem.addr  = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign dmem.be    = be_q;
  assign dmem.wdata = wdata_q;
  assign stall_o    = stall_s & ~rst_i;

  assign rd_addr_o  = rd_addr_q;
  assign rd_data_o  = rd_data_q;
  assign rd_we_o    = rd_we_q;
  assign misalign_o = misalign_q;
  assign badaddr_o  = badaddr_q;
  assign bus_err_o  = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu (XLEN=32): directed scenarios plus
// randomized instructions checked against an arithmetic reference model.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  localparam int XLEN = 32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, rd_we_i, mem_re_i, mem_we_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i, mem_addr_i, store_data_i;
  logic [2:0]  opfunc3_i;
  logic        stall_o, rd_we_o, misalign_o, bus_err_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o, badaddr_o;

  int errors = 0;
  int checks = 0;

  // Observations gathered by mem_access
  int          stall_n, req_n;
  logic        bubble_we, held, obs_we;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;

  mem_stage_lsu_if #(.XLEN(XLEN)) dmem_bus ();

  mem_stage_lsu #(.XLEN(XLEN), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .rd_addr_i(rd_addr_i),
    .rd_data_i(rd_data_i), .rd_we_i(rd_we_i), .mem_addr_i(mem_addr_i),
    .store_data_i(store_data_i), .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
    .opfunc3_i(opfunc3_i), .dmem(dmem_bus), .stall_o(stall_o),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_we_o(rd_we_o),
    .misalign_o(misalign_o), .badaddr_o(badaddr_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_illegal(input logic [2:0] f3, input logic st);
    int code = int'(f3);
    if (code == 7 || code == 3 || code == 6) return 1'b1;
    if (st && code > 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_aligned(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a % 32'd4) % m_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int v = ((1 << m_size(f3)) - 1) << int'(a % 32'd4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w = 32'd0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % m_size(f3)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
    int          sz   = m_size(f3);
    logic [31:0] v    = rdata >> (8 * int'(a % 32'd4));
    logic [31:0] mask;
    if (sz < 4) begin
      mask = (32'd1 << (8 * sz)) - 32'd1;
      v    = v & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic set_idle();
    valid_i = 1'b0; mem_re_i = 1'b0; mem_we_i = 1'b0; rd_we_i = 1'b0;
    opfunc3_i = 3'b000; mem_addr_i = 32'd0; store_data_i = 32'd0;
    rd_data_i = 32'd0; rd_addr_i = 5'd0;
  endtask

  // Present one instruction, act as memory (ack after wait_n BUSY cycles), return once it retires
  task automatic mem_access(input logic v, input logic re, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] alu,
                            input logic [4:0] rd, input logic rdwe, input logic [31:0] rdata,
                            input int wait_n);
    int   busy_n = 0;
    logic done   = 1'b0;
    valid_i = v; mem_re_i = re; mem_we_i = we; opfunc3_i = f3; mem_addr_i = addr;
    store_data_i = sd; rd_data_i = alu; rd_addr_i = rd; rd_we_i = rdwe;
    stall_n = 0; req_n = 0; bubble_we = 1'b0; held = 1'b1;
    obs_addr = 32'd0; obs_be = 4'd0; obs_wdata = 32'd0; obs_we = 1'b0;
    for (int c = 0; c < 32 && !done; c++) begin
      if (c > 0 && rd_we_o === 1'b1) bubble_we = 1'b1;
      if (dmem_bus.req === 1'b1) begin
        if (req_n == 0) begin
          obs_addr = dmem_bus.addr; obs_be = dmem_bus.be;
          obs_wdata = dmem_bus.wdata; obs_we = dmem_bus.we;
        end else if (dmem_bus.addr !== obs_addr || dmem_bus.be !== obs_be ||
                     dmem_bus.wdata !== obs_wdata || dmem_bus.we !== obs_we) begin
          held = 1'b0;
        end
        req_n++;
        if (busy_n == wait_n) begin
          dmem_bus.rdata = rdata;
          dmem_bus.ack   = 1'b1;
        end
        busy_n++;
      end
      #1;
      if (stall_o === 1'b1) stall_n++;
      done = (stall_o !== 1'b1);
      @(posedge clk_i); #1;
      dmem_bus.ack   = 1'b0;
      dmem_bus.rdata = $urandom;
    end
    set_idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1; set_idle();
    dmem_bus.ack = 1'b0; dmem_bus.rdata = 32'd0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (rd_we_o !== 1'b0 || rd_addr_o !== 5'd0 || rd_data_o !== 32'd0) begin
      errors++; $display("FAIL reset_wb: got we=%b rd=%0d data=%h expected 0/0/0", rd_we_o, rd_addr_o, rd_data_o);
    end
    checks++; if (misalign_o !== 1'b0 || badaddr_o !== 32'd0 || bus_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got mis=%b bad=%h berr=%b expected 0", misalign_o, badaddr_o, bus_err_o);
    end
    checks++; if (dmem_bus.req !== 1'b0 || stall_o !== 1'b0) begin
      errors++; $display("FAIL reset_req: got req=%b stall=%b expected 0/0", dmem_bus.req, stall_o);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_store_byte();
    mem_access(1'b1, 1'b0, 1'b1, F3_LB, 32'h0000_1003, 32'h0000_00A5, 32'd0, 5'd7, 1'b0, 32'd0, 2);
    checks++; if (obs_addr !== 32'h0000_1000 || obs_be !== 4'b1000 || obs_we !== 1'b1) begin
      errors++; $display("FAIL sb_bus: got addr=%h be=%b we=%b expected 00001000/1000/1", obs_addr, obs_be, obs_we);
    end
    checks++; if (obs_wdata !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", obs_wdata);
    end
    checks++; if (stall_n != 3 || req_n != 3 || !held) begin
      errors++; $display("FAIL sb_stall: got stall=%0d req=%0d held=%b expected 3/3/1", stall_n, req_n, held);
    end
    checks++; if (rd_we_o !== 1'b0 || bubble_we) begin
      errors++; $display("FAIL sb_rdwe: got we=%b bubble=%b expected 0/0", rd_we_o, bubble_we);
    end
  endtask

  task automatic test_load_extend();
    mem_access(1'b1, 1'b1, 1'b0, F3_LB, 32'h0000_2001, 32'd0, 32'd0, 5'd4, 1'b1, 32'h0000_8000, 0);
    checks++; if (rd_data_o !== 32'hFFFF_FF80 || rd_we_o !== 1'b1 || rd_addr_o !== 5'd4) begin
      errors++; $display("FAIL lb_sext: got data=%h we=%b rd=%0d expected ffffff80/1/4", rd_data_o, rd_we_o, rd_addr_o);
    end
    checks++; if (stall_n != 1 || obs_addr !== 32'h0000_2000) begin
      errors++; $display("FAIL lb_lat: got stall=%0d addr=%h expected 1/00002000", stall_n, obs_addr);
    end
    mem_access(1'b1, 1'b1, 1'b0, F3_LBU, 32'h0000_2001, 32'd0, 32'd0, 5'd4, 1'b1, 32'h0000_8000, 0);
    checks++; if (rd_data_o !== 32'h0000_0080 || rd_we_o !== 1'b1) begin
      errors++; $display("FAIL lbu_zext: got data=%h we=%b expected 00000080/1", rd_data_o, rd_we_o);
    end
  endtask

  task automatic test_misalign();
    mem_access(1'b1, 1'b1, 1'b0, F3_LH, 32'h0000_2003, 32'd0, 32'd0, 5'd6, 1'b1, 32'd0, 0);
    checks++; if (req_n != 0 || stall_n != 0) begin
      errors++; $display("FAIL mis_noreq: got req=%0d stall=%0d expected 0/0", req_n, stall_n);
    end
    checks++; if (misalign_o !== 1'b1 || badaddr_o !== 32'h0000_2003 || rd_we_o !== 1'b0) begin
      errors++; $display("FAIL mis_flag: got mis=%b bad=%h we=%b expected 1/00002003/0", misalign_o, badaddr_o, rd_we_o);
    end
    @(posedge clk_i); #1;
    checks++; if (misalign_o !== 1'b0) begin
      errors++; $display("FAIL mis_pulse: got %b expected 0", misalign_o);
    end
  endtask

  task automatic test_illegal();
    mem_access(1'b1, 1'b1, 1'b0, F3_LD, 32'h0000_4000, 32'd0, 32'd0, 5'd8, 1'b1, 32'd0, 0);
    checks++; if (req_n != 0 || misalign_o !== 1'b0 || rd_we_o !== 1'b0) begin
      errors++; $display("FAIL ill_ld: got req=%0d mis=%b we=%b expected 0/0/0", req_n, misalign_o, rd_we_o);
    end
    mem_access(1'b1, 1'b0, 1'b1, F3_LBU, 32'h0000_4000, 32'h1, 32'd0, 5'd8, 1'b0, 32'd0, 0);
    checks++; if (req_n != 0 || stall_n != 0 || misalign_o !== 1'b0) begin
      errors++; $display("FAIL ill_st: got req=%0d stall=%0d mis=%b expected 0/0/0", req_n, stall_n, misalign_o);
    end
  endtask

  task automatic test_back_to_back();
    mem_access(1'b1, 1'b1, 1'b0, F3_LW, 32'h0000_3000, 32'd0, 32'd0, 5'd3, 1'b1, 32'hCAFE_F00D, 0);
    valid_i = 1'b1; rd_addr_i = 5'd5; rd_data_i = 32'h0000_1234; rd_we_i = 1'b1;
    checks++; if (rd_data_o !== 32'hCAFE_F00D || rd_addr_o !== 5'd3 || rd_we_o !== 1'b1 || stall_n != 1) begin
      errors++; $display("FAIL b2b_load: got data=%h rd=%0d we=%b stall=%0d expected cafef00d/3/1/1", rd_data_o, rd_addr_o, rd_we_o, stall_n);
    end
    #1;
    checks++; if (stall_o !== 1'b0) begin
      errors++; $display("FAIL b2b_nostall: got %b expected 0", stall_o);
    end
    @(posedge clk_i); #1;
    set_idle();
    checks++; if (rd_data_o !== 32'h0000_1234 || rd_addr_o !== 5'd5 || rd_we_o !== 1'b1) begin
      errors++; $display("FAIL b2b_add: got data=%h rd=%0d we=%b expected 00001234/5/1", rd_data_o, rd_addr_o, rd_we_o);
    end
    @(posedge clk_i); #1;
    checks++; if (rd_we_o !== 1'b0) begin
      errors++; $display("FAIL b2b_dup: got we=%b expected 0", rd_we_o);
    end
  endtask

  task automatic test_reset_busy();
    valid_i = 1'b1; mem_re_i = 1'b1; opfunc3_i = F3_LW; mem_addr_i = 32'h0000_5000;
    rd_addr_i = 5'd9; rd_we_i = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (dmem_bus.req !== 1'b1) begin
      errors++; $display("FAIL rstb_busy: got req=%b expected 1", dmem_bus.req);
    end
    #2; rst_i = 1'b1; dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (dmem_bus.req !== 1'b0 || stall_o !== 1'b0) begin
      errors++; $display("FAIL rstb_drop: got req=%b stall=%b expected 0/0", dmem_bus.req, stall_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0; set_idle();
    @(posedge clk_i); #1;
    checks++; if (rd_we_o !== 1'b0 || dmem_bus.req !== 1'b0 || rd_data_o !== 32'd0) begin
      errors++; $display("FAIL rstb_stale: got we=%b req=%b data=%h expected 0/0/0", rd_we_o, dmem_bus.req, rd_data_o);
    end
    dmem_bus.ack = 1'b0;
    mem_access(1'b1, 1'b1, 1'b0, F3_LW, 32'h0000_5004, 32'd0, 32'd0, 5'd9, 1'b1, 32'h1122_3344, 1);
    checks++; if (rd_data_o !== 32'h1122_3344 || rd_we_o !== 1'b1 || req_n != 2) begin
      errors++; $display("FAIL rstb_new: got data=%h we=%b req=%0d expected 11223344/1/2", rd_data_o, rd_we_o, req_n);
    end
  endtask

`ifdef MEM_STAGE_TIMEOUT_EN
  task automatic test_timeout();
    mem_access(1'b1, 1'b1, 1'b0, F3_LW, 32'h0000_6000, 32'd0, 32'd0, 5'd2, 1'b1, 32'd0, 1000);
    checks++; if (bus_err_o !== 1'b1 || req_n != 4 || rd_we_o !== 1'b0 || badaddr_o !== 32'h0000_6000) begin
      errors++; $display("FAIL timeout: got berr=%b req=%0d we=%b bad=%h expected 1/4/0/00006000", bus_err_o, req_n, rd_we_o, badaddr_o);
    end
    checks++; if (dmem_bus.req !== 1'b0 || stall_n != 4) begin
      errors++; $display("FAIL timeout_drop: got req=%b stall=%0d expected 0/4", dmem_bus.req, stall_n);
    end
    @(posedge clk_i); #1;
    checks++; if (bus_err_o !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: got %b expected 0", bus_err_o);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      int          kind   = $urandom_range(0, 3);
      logic        v      = ($urandom_range(0, 7) != 0);
      logic        re     = (kind == 1) || (kind == 3);
      logic        we     = (kind == 2) || (kind == 3);
      logic [2:0]  f3     = 3'($urandom_range(0, 7));
      logic [31:0] addr   = $urandom;
      logic [31:0] sd     = $urandom;
      logic [31:0] alu    = $urandom;
      logic [31:0] rdata  = $urandom;
      logic [4:0]  rd     = 5'($urandom_range(0, 31));
      logic        rdwe   = $urandom_range(0, 1) != 0;
      int          wait_n = $urandom_range(0, 3);
      logic        memop  = v & (re | we);
      if ($urandom_range(0, 1) != 0) addr[1:0] = 2'b00;
      mem_access(v, re, we, f3, addr, sd, alu, rd, rdwe, rdata, wait_n);
      checks++;
      if (!memop) begin
        if ({rd_we_o, rd_addr_o, rd_data_o} !== {rdwe & v, rd, alu} || req_n != 0) begin
          errors++; $display("FAIL rnd_alu[%0d]: got we=%b rd=%0d data=%h req=%0d expected %b/%0d/%h/0", n, rd_we_o, rd_addr_o, rd_data_o, req_n, rdwe & v, rd, alu);
        end
      end else if (m_illegal(f3, we)) begin
        if (req_n != 0 || rd_we_o !== 1'b0 || misalign_o !== 1'b0) begin
          errors++; $display("FAIL rnd_illegal[%0d]: got req=%0d we=%b mis=%b f3=%0d expected 0/0/0", n, req_n, rd_we_o, misalign_o, f3);
        end
      end else if (!m_aligned(f3, addr)) begin
        if (req_n != 0 || misalign_o !== 1'b1 || badaddr_o !== addr || rd_we_o !== 1'b0) begin
          errors++; $display("FAIL rnd_misalign[%0d]: got req=%0d mis=%b bad=%h we=%b expected 0/1/%h/0", n, req_n, misalign_o, badaddr_o, rd_we_o, addr);
        end
      end else if (req_n != wait_n + 1 || stall_n != wait_n + 1 || !held || bubble_we ||
                   obs_addr !== {addr[31:2], 2'b00} || obs_we !== we) begin
        errors++; $display("FAIL rnd_hs[%0d]: got req=%0d stall=%0d held=%b addr=%h we=%b expected %0d/%0d/1/%h/%b", n, req_n, stall_n, held, obs_addr, obs_we, wait_n + 1, wait_n + 1, {addr[31:2], 2'b00}, we);
      end else if (we) begin
        if (obs_be !== m_be(f3, addr) || obs_wdata !== m_wdata(f3, sd) || rd_we_o !== 1'b0) begin
          errors++; $display("FAIL rnd_store[%0d]: got be=%b wdata=%h we=%b expected %b/%h/0", n, obs_be, obs_wdata, rd_we_o, m_be(f3, addr), m_wdata(f3, sd));
        end
      end else begin
        if (rd_data_o !== m_load(f3, addr, rdata) || rd_we_o !== rdwe || rd_addr_o !== rd) begin
          errors++; $display("FAIL rnd_load[%0d]: got data=%h we=%b rd=%0d expected %h/%b/%0d", n, rd_data_o, rd_we_o, rd_addr_o, m_load(f3, addr, rdata), rdwe, rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_extend();
    test_misalign();
    test_illegal();
    test_back_to_back();
    test_reset_busy();
`ifdef MEM_STAGE_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
